// File: rtl/imm_decode_ctrl.sv
// imm_decode_ctrl
//   Two-stage decode controller sitting in front of the shared immediate
//   generator. Stage D holds one fetched instruction and derives the
//   immediate select from its opcode. Stage X (the output register) captures
//   the generator's immediate together with pc, pc+imm target, opcode and an
//   illegal-opcode flag. A saturating counter tracks cycles where execute
//   stalls a valid output.
//
// Ports
//   clk, reset_n              clock, synchronous active-low reset
//   in_valid/in_ready         fetch handshake; in_instr, in_pc carry the entry
//   flush                     squash both stages (redirect)
//   imm_instr, imm_sel        request to the immediate generator
//   imm_value                 immediate returned combinationally by generator
//   out_valid/out_ready       execute handshake
//   out_imm, out_pc,
//   out_target, out_opcode,
//   out_illegal               decoded entry fields
//   stall_cnt                 saturating count of out_valid && !out_ready cycles

module imm_decode_ctrl #(
    parameter int          STALL_CNT_W = 16,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic [31:0]            in_pc,
    input  logic                   flush,
    output logic [31:0]            imm_instr,
    output logic [2:0]             imm_sel,
    input  logic [31:0]            imm_value,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_imm,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_target,
    output logic [6:0]             out_opcode,
    output logic                   out_illegal,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic [2:0] {
        SEL_I    = 3'd0,
        SEL_S    = 3'd1,
        SEL_B    = 3'd2,
        SEL_J    = 3'd3,
        SEL_NONE = 3'd4
    } imm_sel_e;

    localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);

    logic        d_valid;
    logic [31:0] d_instr;
    logic [31:0] d_pc;

    imm_sel_e    dec_sel;
    logic        dec_illegal;
    logic        x_adv;
    logic        d_adv;
    logic        in_fire;

    // Opcode decode of the held instruction. Opcodes that carry no immediate
    // still select "none"; anything unrecognised is also "none" but flagged.
    always_comb begin
        dec_sel     = SEL_NONE;
        dec_illegal = 1'b0;
        case (d_instr[6:0])
            7'b0010011,
            7'b0000011,
            7'b1100111: dec_sel = SEL_I;
            7'b0100011: dec_sel = SEL_S;
            7'b1100011: dec_sel = SEL_B;
            7'b1101111: dec_sel = SEL_J;
            7'b0110011,
            7'b0110111,
            7'b0010111: dec_sel = SEL_NONE;
            default:    dec_illegal = 1'b1;
        endcase
    end

    // The generator is shared, so an empty D stage presents a quiet request.
    assign imm_sel   = d_valid ? dec_sel : SEL_NONE;
    assign imm_instr = d_valid ? d_instr : 32'h0;

    // Each stage may move when its downstream slot is free or being drained,
    // which gives full throughput with simultaneous fill and drain.
    assign x_adv    = !out_valid || out_ready;
    assign d_adv    = d_valid && x_adv;
    assign in_ready = !d_valid || x_adv;
    assign in_fire  = in_valid && in_ready;

    // Pipeline registers. Flush squashes both valids and drops any incoming
    // instruction; data fields simply hold since valid gates their meaning.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            d_valid     <= 1'b0;
            d_instr     <= 32'h0;
            d_pc        <= 32'h0;
            out_valid   <= 1'b0;
            out_imm     <= 32'h0;
            out_pc      <= RESET_PC;
            out_target  <= 32'h0;
            out_opcode  <= 7'h0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            d_valid   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (in_fire) begin
                d_valid <= 1'b1;
                d_instr <= in_instr;
                d_pc    <= in_pc;
            end else if (d_adv) begin
                d_valid <= 1'b0;
            end

            if (d_adv) begin
                out_valid   <= 1'b1;
                out_imm     <= imm_value;
                out_pc      <= d_pc;
                out_target  <= d_pc + imm_value;
                out_opcode  <= d_instr[6:0];
                out_illegal <= dec_illegal;
            end else if (x_adv) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Stall counter for performance monitoring; sticks at all-ones instead
    // of wrapping so a long stall never reads as a short one.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// tb_imm_decode_ctrl
//   Directed bench for imm_decode_ctrl. A behavioural immediate generator
//   answers the DUT's requests; a monitor pushes a reference entry for every
//   accepted instruction and pops/compares it on every drained output.

module tb_imm_decode_ctrl;

    localparam int          CW  = 4;
    localparam logic [31:0] RPC = 32'hDEAD_BEE0;

    localparam logic [31:0] ADDI = 32'hFFF0_0093;
    localparam logic [31:0] SW   = 32'h0011_2623;
    localparam logic [31:0] BEQ  = 32'hFE00_0CE3;
    localparam logic [31:0] JAL  = 32'h0100_006F;
    localparam logic [31:0] BA   = 32'h0050_0093;
    localparam logic [31:0] BB   = 32'h00A1_2023;
    localparam logic [31:0] BC   = 32'h0020_8463;
    localparam logic [31:0] FX   = 32'h0010_0113;
    localparam logic [31:0] FY   = 32'h0040_006F;
    localparam logic [31:0] FZ   = 32'h1234_5037;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instr;
    logic [31:0]   in_pc;
    logic          flush;
    logic [31:0]   imm_instr;
    logic [2:0]    imm_sel;
    logic [31:0]   imm_value;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_imm;
    logic [31:0]   out_pc;
    logic [31:0]   out_target;
    logic [6:0]    out_opcode;
    logic          out_illegal;
    logic [CW-1:0] stall_cnt;

    typedef struct {
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] target;
        logic [6:0]  opcode;
        logic        illegal;
    } exp_t;

    exp_t sbQ[$];
    exp_t monEntry;
    int   checks     = 0;
    int   failures   = 0;
    int   drainCount = 0;
    int   d0;
    int   expStall;

    imm_decode_ctrl #(
        .STALL_CNT_W (CW),
        .RESET_PC    (RPC)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .flush       (flush),
        .imm_instr   (imm_instr),
        .imm_sel     (imm_sel),
        .imm_value   (imm_value),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_pc      (out_pc),
        .out_target  (out_target),
        .out_opcode  (out_opcode),
        .out_illegal (out_illegal),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural RISC-V immediate generator
    function automatic logic [31:0] genImm(input logic [31:0] i, input logic [2:0] sel);
        case (sel)
            3'd0:    return {{20{i[31]}}, i[31:20]};
            3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    // Reference opcode classification
    function automatic logic [2:0] refSel(input logic [6:0] op);
        if (op == 7'h13 || op == 7'h03 || op == 7'h67) return 3'd0;
        if (op == 7'h23) return 3'd1;
        if (op == 7'h63) return 3'd2;
        if (op == 7'h6F) return 3'd3;
        return 3'd4;
    endfunction

    function automatic logic refIllegal(input logic [6:0] op);
        return !(op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h23 ||
                 op == 7'h63 || op == 7'h6F || op == 7'h33 || op == 7'h37 ||
                 op == 7'h17);
    endfunction

    function automatic exp_t makeExp(input logic [31:0] instr, input logic [31:0] pc);
        exp_t e;
        e.imm     = genImm(instr, refSel(instr[6:0]));
        e.pc      = pc;
        e.target  = pc + e.imm;
        e.opcode  = instr[6:0];
        e.illegal = refIllegal(instr[6:0]);
        return e;
    endfunction

    assign imm_value = genImm(imm_instr, imm_sel);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor, sampling mid-cycle when inputs are settled
    always @(negedge clk) begin
        if (!reset_n || flush) begin
            sbQ.delete();
        end else begin
            if (out_valid && out_ready) begin
                drainCount++;
                checks++;
                assert (sbQ.size() > 0) else begin
                    failures++;
                    $error("[TB] FAIL unexpected_output: observed pc=0x%08h expected no output", out_pc);
                end
                if (sbQ.size() > 0) begin
                    monEntry = sbQ.pop_front();
                    checkOutput("sb_imm",     out_imm,               monEntry.imm);
                    checkOutput("sb_pc",      out_pc,                monEntry.pc);
                    checkOutput("sb_target",  out_target,            monEntry.target);
                    checkOutput("sb_opcode",  32'(out_opcode),       32'(monEntry.opcode));
                    checkOutput("sb_illegal", 32'(out_illegal),      32'(monEntry.illegal));
                end
            end
            if (in_valid && in_ready) sbQ.push_back(makeExp(in_instr, in_pc));
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed no completion expected finish");
        $fatal(1);
    end

    initial begin
        // Reset held two cycles with fetch active
        reset_n   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        applyStimulus(1'b1, ADDI, 32'h100);
        tick();
        tick();
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
        checkOutput("rst_stall",     32'(stall_cnt), 32'd0);
        checkOutput("rst_out_pc",    out_pc,         RPC);
        checkOutput("rst_imm_sel",   32'(imm_sel),   32'd4);
        checkOutput("rst_imm_instr", imm_instr,      32'h0);

        // Back-to-back stream of the four immediate formats
        reset_n   = 1'b1;
        out_ready = 1'b1;
        d0        = drainCount;
        applyStimulus(1'b1, ADDI, 32'h100);
        tick();
        checkOutput("lat1_out_valid", 32'(out_valid), 32'd0);
        checkOutput("sel_addi",       32'(imm_sel),   32'd0);
        checkOutput("instr_addi",     imm_instr,      ADDI);
        applyStimulus(1'b1, SW, 32'h100);
        tick();
        checkOutput("lat2_out_valid", 32'(out_valid), 32'd1);
        checkOutput("sel_sw",         32'(imm_sel),   32'd1);
        checkOutput("imm_addi",       out_imm,        32'hFFFF_FFFF);
        applyStimulus(1'b1, BEQ, 32'h100);
        tick();
        checkOutput("sel_beq",        32'(imm_sel),   32'd2);
        checkOutput("imm_sw",         out_imm,        32'h0000_000C);
        applyStimulus(1'b1, JAL, 32'h100);
        tick();
        checkOutput("sel_jal",        32'(imm_sel),   32'd3);
        checkOutput("imm_beq",        out_imm,        32'hFFFF_FFF8);
        checkOutput("target_beq",     out_target,     32'h0000_00F8);
        applyStimulus(1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("imm_jal",        out_imm,        32'h0000_0010);
        checkOutput("target_jal",     out_target,     32'h0000_0110);
        tick();
        checkOutput("stream_drained", 32'(out_valid),          32'd0);
        checkOutput("stream_count",   32'(drainCount - d0),    32'd4);
        checkOutput("stream_stall",   32'(stall_cnt),          32'd0);

        // Backpressure: two accepts fill the pipe, third waits
        d0        = drainCount;
        out_ready = 1'b0;
        applyStimulus(1'b1, BA, 32'h200);
        tick();
        checkOutput("bp_ready_1", 32'(in_ready), 32'd1);
        applyStimulus(1'b1, BB, 32'h204);
        tick();
        checkOutput("bp_ready_full", 32'(in_ready),  32'd0);
        checkOutput("bp_out_valid",  32'(out_valid), 32'd1);
        applyStimulus(1'b1, BC, 32'h208);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_hold_pc",    out_pc,         32'h200);
            checkOutput("bp_hold_imm",   out_imm,        32'h5);
            checkOutput("bp_hold_ready", 32'(in_ready),  32'd0);
            checkOutput("bp_stall",      32'(stall_cnt), 32'(i + 1));
        end
        out_ready = 1'b1;
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0);
        tick();
        tick();
        checkOutput("bp_drained",   32'(out_valid),       32'd0);
        checkOutput("bp_count",     32'(drainCount - d0), 32'd3);
        checkOutput("bp_sb_empty",  32'(sbQ.size()),      32'd0);
        checkOutput("bp_stall_end", 32'(stall_cnt),       32'd5);

        // Flush with both stages full and a new instruction offered
        d0        = drainCount;
        out_ready = 1'b0;
        applyStimulus(1'b1, FX, 32'h300);
        tick();
        applyStimulus(1'b1, FY, 32'h304);
        tick();
        checkOutput("fl_pre_ready", 32'(in_ready),  32'd0);
        checkOutput("fl_pre_valid", 32'(out_valid), 32'd1);
        flush = 1'b1;
        applyStimulus(1'b1, FZ, 32'h308);
        tick();
        checkOutput("fl_out_valid", 32'(out_valid), 32'd0);
        checkOutput("fl_d_empty",   32'(imm_sel),   32'd4);
        checkOutput("fl_imm_instr", imm_instr,      32'h0);
        checkOutput("fl_in_ready",  32'(in_ready),  32'd1);
        checkOutput("fl_stall",     32'(stall_cnt), 32'd5);
        flush     = 1'b0;
        out_ready = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0);
        tick();
        tick();
        checkOutput("fl_no_output", 32'(out_valid),       32'd0);
        checkOutput("fl_count",     32'(drainCount - d0), 32'd0);

        // Illegal opcode followed by a legal no-immediate opcode
        applyStimulus(1'b1, 32'h0000_007F, 32'h400);
        tick();
        checkOutput("ill_sel", 32'(imm_sel), 32'd4);
        applyStimulus(1'b1, 32'h0000_0033, 32'h404);
        tick();
        checkOutput("ill_flag",   32'(out_illegal), 32'd1);
        checkOutput("ill_imm",    out_imm,          32'h0);
        checkOutput("ill_opcode", 32'(out_opcode),  32'h7F);
        checkOutput("r_sel",      32'(imm_sel),     32'd4);
        applyStimulus(1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("r_flag",   32'(out_illegal), 32'd0);
        checkOutput("r_imm",    out_imm,          32'h0);
        checkOutput("r_opcode", 32'(out_opcode),  32'h33);
        tick();
        checkOutput("ill_drained", 32'(out_valid), 32'd0);

        // Long stall to saturate the counter, then reset mid-stream
        out_ready = 1'b0;
        expStall  = 5;
        applyStimulus(1'b1, SW, 32'h500);
        tick();
        applyStimulus(1'b1, BEQ, 32'h504);
        tick();
        checkOutput("sat_out_valid", 32'(out_valid), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (expStall < 15) expStall++;
            checkOutput("sat_stall", 32'(stall_cnt), 32'(expStall));
        end
        reset_n = 1'b0;
        tick();
        checkOutput("mrst_out_valid", 32'(out_valid),   32'd0);
        checkOutput("mrst_stall",     32'(stall_cnt),   32'd0);
        checkOutput("mrst_out_pc",    out_pc,           RPC);
        checkOutput("mrst_out_imm",   out_imm,          32'h0);
        checkOutput("mrst_target",    out_target,       32'h0);
        checkOutput("mrst_opcode",    32'(out_opcode),  32'h0);
        checkOutput("mrst_illegal",   32'(out_illegal), 32'd0);
        checkOutput("mrst_in_ready",  32'(in_ready),    32'd1);
        checkOutput("mrst_imm_sel",   32'(imm_sel),     32'd4);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        d0        = drainCount;
        tick();
        tick();
        checkOutput("mrst_no_partial", 32'(out_valid),       32'd0);
        checkOutput("mrst_count",      32'(drainCount - d0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
